// File: rtl/pri_irq_ctrl.sv
// Interrupt request controller around an external 8-input priority circuit.
// Optional source masking is enabled with `define PRI_IRQ_MASK_EN.
module pri_irq_ctrl #(
   parameter int unsigned EDGE_DET = 1,
   parameter int unsigned VEC_W    = 3,
   localparam int unsigned N_SRC   = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [N_SRC-1:0] req_in,
   output logic [N_SRC-1:0] pend_o,
   input  logic [N_SRC-1:0] hot_i,
   input  logic             idle_i,
   output logic             irq,
   output logic [VEC_W-1:0] vec,
   input  logic             ack,
   output logic             err
`ifdef PRI_IRQ_MASK_EN
   ,input logic [N_SRC-1:0] mask
`endif
);

   typedef enum logic [1:0] {S_IDLE, S_REQ, S_DONE} state_t;

   state_t             state;
   state_t             state_nxt;
   logic [N_SRC-1:0]   req_q;
   logic [N_SRC-1:0]   pend;
   logic [N_SRC-1:0]   set_bits;
   logic [N_SRC-1:0]   clr_bits;
   logic               armed;
   logic               irq_nxt;
   logic               err_nxt;
   logic [VEC_W-1:0]   vec_nxt;

   // Highest set index of the grant vector; zero when no bit is set.
   function automatic logic [VEC_W-1:0] encode(input logic [N_SRC-1:0] h);
      logic [VEC_W-1:0] idx;
      idx = '0;
      for (int i = 0; i < int'(N_SRC); i++) begin
         if (h[i]) idx = VEC_W'(i);
      end
      return idx;
   endfunction

   // A line already high when reset lifts is not an edge: armed blanks the first cycle.
   assign set_bits = (EDGE_DET != 0) ? (req_in & ~req_q & {N_SRC{armed}}) : req_in;

`ifdef PRI_IRQ_MASK_EN
   assign pend_o = pend & ~mask;
`else
   assign pend_o = pend;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= S_IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:  if (!idle_i) state_nxt = S_REQ;
         S_REQ:   if (ack)     state_nxt = S_DONE;
         S_DONE:  state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   // Grant capture in S_IDLE, ack handling in S_REQ; vec stays frozen otherwise.
   always_comb begin
      irq_nxt  = 1'b0;
      vec_nxt  = vec;
      err_nxt  = err;
      clr_bits = '0;
      case (state)
         S_IDLE: begin
            if (!idle_i) begin
               irq_nxt = 1'b1;
               vec_nxt = encode(hot_i);
               if (!$onehot(hot_i)) err_nxt = 1'b1;
            end
         end
         S_REQ: begin
            irq_nxt = !ack;
            if (ack) clr_bits = N_SRC'(1) << vec;
         end
         default: irq_nxt = 1'b0;
      endcase
   end

   // Set wins over clear on the same bit.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         req_q <= '0;
         armed <= 1'b0;
         pend  <= '0;
         irq   <= 1'b0;
         vec   <= '0;
         err   <= 1'b0;
      end else begin
         req_q <= req_in;
         armed <= 1'b1;
         pend  <= (pend & ~clr_bits) | set_bits;
         irq   <= irq_nxt;
         vec   <= vec_nxt;
         err   <= err_nxt;
      end
   end

endmodule

// File: tb/tb_pri_irq_ctrl.sv
// Self-checking bench for pri_irq_ctrl: directed vector table, random run
// against a behavioural model, and hand-written reset/error/mask sequences.
module tb_pri_irq_ctrl;

   localparam int unsigned EDGE = 1;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic [7:0] req_in = '0;
   logic [7:0] pend_o;
   logic [7:0] hot_i;
   logic       idle_i;
   logic       irq;
   logic [2:0] vec;
   logic       ack = 1'b0;
   logic       err;
`ifdef PRI_IRQ_MASK_EN
   logic [7:0] mask = '0;
`endif

   logic       ovr_en   = 1'b0;
   logic [7:0] ovr_hot  = '0;
   logic       ovr_idle = 1'b1;
   logic [7:0] prio_hot;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   pri_irq_ctrl #(.EDGE_DET(EDGE), .VEC_W(3)) dut (
      .clk    (clk),
      .rst    (rst),
      .req_in (req_in),
      .pend_o (pend_o),
      .hot_i  (hot_i),
      .idle_i (idle_i),
      .irq    (irq),
      .vec    (vec),
      .ack    (ack),
      .err    (err)
`ifdef PRI_IRQ_MASK_EN
      ,.mask  (mask)
`endif
   );

   // Stand-in priority circuit: highest index wins.
   always_comb begin
      prio_hot = '0;
      for (int i = 0; i < 8; i++) begin
         if (pend_o[i]) prio_hot = 8'(1) << i;
      end
   end
   assign hot_i  = ovr_en ? ovr_hot  : prio_hot;
   assign idle_i = ovr_en ? ovr_idle : (pend_o == 8'h00);

   typedef struct {
      logic [7:0] req;
      logic       ack;
      logic [7:0] pend;
      logic       irq;
      logic [2:0] vec;
   } row_t;

   row_t tbl [29];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic do_reset();
      rst    = 1'b1;
      req_in = '0;
      ack    = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      repeat (2) @(posedge clk);
      #1;
   endtask

   function automatic int top_idx(input logic [7:0] p);
      for (int i = 7; i >= 0; i--) if (p[i]) return i;
      return 0;
   endfunction

   // Behavioural model state
   logic [7:0] m_pend;
   logic [7:0] m_prev;
   logic       m_irq;
   int         m_vec;
   int         m_cool;

   initial begin
      logic [7:0] set_m;
      logic [7:0] clr_m;
      logic [7:0] r;
      logic       a;
      int         n;

      //                 req    ack   pend   irq   vec
      tbl[0]  = '{8'h10, 1'b0, 8'h10, 1'b0, 3'd0};
      tbl[1]  = '{8'h00, 1'b0, 8'h10, 1'b1, 3'd4};
      tbl[2]  = '{8'h00, 1'b1, 8'h00, 1'b0, 3'd0};
      tbl[3]  = '{8'h00, 1'b0, 8'h00, 1'b0, 3'd0};
      tbl[4]  = '{8'h05, 1'b0, 8'h05, 1'b0, 3'd0};
      tbl[5]  = '{8'h00, 1'b0, 8'h05, 1'b1, 3'd2};
      tbl[6]  = '{8'h00, 1'b1, 8'h01, 1'b0, 3'd0};
      tbl[7]  = '{8'h00, 1'b0, 8'h01, 1'b0, 3'd0};
      tbl[8]  = '{8'h00, 1'b0, 8'h01, 1'b1, 3'd0};
      tbl[9]  = '{8'h00, 1'b1, 8'h00, 1'b0, 3'd0};
      tbl[10] = '{8'h00, 1'b1, 8'h00, 1'b0, 3'd0};
      tbl[11] = '{8'h02, 1'b1, 8'h02, 1'b0, 3'd0};
      tbl[12] = '{8'h00, 1'b1, 8'h02, 1'b1, 3'd1};
      tbl[13] = '{8'h80, 1'b0, 8'h82, 1'b1, 3'd1};
      tbl[14] = '{8'h80, 1'b0, 8'h82, 1'b1, 3'd1};
      tbl[15] = '{8'h00, 1'b1, 8'h80, 1'b0, 3'd0};
      tbl[16] = '{8'h00, 1'b0, 8'h80, 1'b0, 3'd0};
      tbl[17] = '{8'h00, 1'b0, 8'h80, 1'b1, 3'd7};
      tbl[18] = '{8'h00, 1'b1, 8'h00, 1'b0, 3'd0};
      tbl[19] = '{8'h00, 1'b0, 8'h00, 1'b0, 3'd0};
      tbl[20] = '{8'h00, 1'b0, 8'h00, 1'b0, 3'd0};
      tbl[21] = '{8'h08, 1'b0, 8'h08, 1'b0, 3'd0};
      tbl[22] = '{8'h00, 1'b0, 8'h08, 1'b1, 3'd3};
      tbl[23] = '{8'h00, 1'b0, 8'h08, 1'b1, 3'd3};
      tbl[24] = '{8'h08, 1'b1, 8'h08, 1'b0, 3'd0};
      tbl[25] = '{8'h00, 1'b0, 8'h08, 1'b0, 3'd0};
      tbl[26] = '{8'h00, 1'b0, 8'h08, 1'b1, 3'd3};
      tbl[27] = '{8'h00, 1'b1, 8'h00, 1'b0, 3'd0};
      tbl[28] = '{8'h00, 1'b0, 8'h00, 1'b0, 3'd0};

      // Reset state, checked before any clock edge
      #1 rst = 1'b1;
      #1;
      check("rst_pend", 32'(pend_o), 32'h0);
      check("rst_irq",  32'(irq),    32'h0);
      check("rst_vec",  32'(vec),    32'h0);
      check("rst_err",  32'(err),    32'h0);
      @(negedge clk);
      rst = 1'b0;
      repeat (2) @(posedge clk);
      #1;

      // Directed vector table
      for (int i = 0; i < 29; i++) begin
         req_in = tbl[i].req;
         ack    = tbl[i].ack;
         @(posedge clk);
         #1;
         check($sformatf("tbl%0d_pend", i), 32'(pend_o), 32'(tbl[i].pend));
         check($sformatf("tbl%0d_irq", i),  32'(irq),    32'(tbl[i].irq));
         if (tbl[i].irq) check($sformatf("tbl%0d_vec", i), 32'(vec), 32'(tbl[i].vec));
         check($sformatf("tbl%0d_err", i),  32'(err),    32'h0);
      end
      req_in = '0;
      ack    = 1'b0;

      // Random run against the behavioural model
      do_reset();
      m_pend = '0; m_prev = '0; m_irq = 1'b0; m_vec = 0; m_cool = 0;
      for (int c = 0; c < 400; c++) begin
         r = 8'($urandom & $urandom & $urandom);
         a = m_irq ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 7) == 0);
         req_in = r;
         ack    = a;
         set_m  = (EDGE != 0) ? (r & ~m_prev) : r;
         clr_m  = (m_irq && a) ? (8'(1) << m_vec) : 8'h00;
         if (m_irq) begin
            if (a) begin
               m_irq  = 1'b0;
               m_cool = 1;
            end
         end else if (m_cool != 0) begin
            m_cool = 0;
         end else if (m_pend != 0) begin
            m_irq = 1'b1;
            m_vec = top_idx(m_pend);
         end
         m_pend = (m_pend & ~clr_m) | set_m;
         m_prev = r;
         @(posedge clk);
         #1;
         check("rnd_pend", 32'(pend_o), 32'(m_pend));
         check("rnd_irq",  32'(irq),    32'(m_irq));
         if (m_irq) check("rnd_vec", 32'(vec), 32'(m_vec));
         check("rnd_err",  32'(err),    32'h0);
      end
      req_in = '0;
      ack    = 1'b0;

      // Request held high through reset release
      rst    = 1'b1;
      req_in = 8'hff;
      @(negedge clk);
      rst = 1'b0;
      for (int c = 0; c < 3; c++) begin
         @(posedge clk);
         #1;
         check("hold_pend", 32'(pend_o), (EDGE != 0) ? 32'h0 : 32'hff);
         if (EDGE != 0) check("hold_irq", 32'(irq), 32'h0);
      end
      req_in = '0;

      // Non-one-hot grant, then asynchronous reset in S_REQ
      do_reset();
      ovr_en   = 1'b1;
      ovr_hot  = 8'h03;
      ovr_idle = 1'b0;
      req_in   = 8'h04;
      @(posedge clk);
      #1;
      req_in = '0;
      check("err_irq",  32'(irq),    32'h1);
      check("err_vec",  32'(vec),    32'h1);
      check("err_err",  32'(err),    32'h1);
      check("err_pend", 32'(pend_o), 32'h04);
      ovr_hot = 8'h40;
      @(posedge clk);
      #1;
      check("err_sticky", 32'(err), 32'h1);
      check("err_freeze", 32'(vec), 32'h1);
      #2 rst = 1'b1;
      #1;
      check("arst_irq",  32'(irq),    32'h0);
      check("arst_vec",  32'(vec),    32'h0);
      check("arst_err",  32'(err),    32'h0);
      check("arst_pend", 32'(pend_o), 32'h0);
      ovr_en   = 1'b0;
      ovr_idle = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      repeat (2) @(posedge clk);
      #1;

`ifdef PRI_IRQ_MASK_EN
      // Masked source latches and is presented once unmasked
      mask   = 8'h80;
      req_in = 8'h80;
      @(posedge clk);
      #1;
      req_in = '0;
      @(posedge clk);
      #1;
      check("mask_pend", 32'(pend_o), 32'h0);
      check("mask_irq",  32'(irq),    32'h0);
      mask = 8'h00;
      #1;
      check("unmask_pend", 32'(pend_o), 32'h80);
      n = 0;
      while (!irq && n < 3) begin
         @(posedge clk);
         #1;
         n++;
      end
      check("unmask_irq", 32'(irq), 32'h1);
      check("unmask_vec", 32'(vec), 32'h7);
      mask = 8'h80;
      @(posedge clk);
      #1;
      check("mask_keep_irq", 32'(irq), 32'h1);
      mask = 8'h00;
      ack  = 1'b1;
      @(posedge clk);
      #1;
      ack = 1'b0;
      check("mask_ack_pend", 32'(pend_o), 32'h0);
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
